// File: rtl/alu_result_packer.sv
// -----------------------------------------------------------------------------
// alu_result_packer
//
// Buffers valid ALU results in a small FIFO and serialises each one into bytes,
// least-significant byte first, for the UART TX path. Lets back-to-back ALU
// results survive while the TX side is back-pressured.
//
// Optional build macro: ALU_PKT_HDR_EN
//   defined   : each packet is prefixed with a header byte {4'hA, ALU_FUN};
//               FIFO entries store {ALU_FUN, ALU_OUT}.
//   undefined : packet is the data bytes only; ALU_FUN is not stored.
//
// Ports:
//   clk        system clock, rising edge
//   RST        synchronous reset, active-high, highest priority
//   ALU_OUT    ALU result word (DATA_WIDTH bits)
//   ALU_FUN    ALU function code accompanying the result
//   OUT_VALID  result qualifier; one capture per cycle it is high
//   TX_READY   downstream accepts a byte this cycle
//   TX_DATA    byte currently offered downstream (registered)
//   TX_VALID   TX_DATA is valid (registered)
//   BUSY       FIFO non-empty or a packet in flight (registered)
//   OVERFLOW   sticky flag: a result was dropped
//   OVF_CLR    clears OVERFLOW (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module alu_result_packer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic [3:0]            ALU_FUN,
    input  logic                  OUT_VALID,
    input  logic                  TX_READY,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
);

    localparam int unsigned NBYTES  = DATA_WIDTH / 8;
`ifdef ALU_PKT_HDR_EN
    localparam int unsigned ENTRY_W = DATA_WIDTH + 4;
    localparam int unsigned PKT_LEN = NBYTES + 1;
`else
    localparam int unsigned ENTRY_W = DATA_WIDTH;
    localparam int unsigned PKT_LEN = NBYTES;
`endif
    localparam int unsigned IDX_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Storage and control state
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   byte_idx;
    state_t             state;

    // Next-state values
    state_t             state_next;
    logic [IDX_W-1:0]   idx_next;
    logic [7:0]         tx_data_next;
    logic               tx_valid_next;
    logic [CNT_W-1:0]   count_next;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] next_entry;
    logic               transfer;
    logic               last_byte;
    logic               pop;
    logic               push;
    logic               drop;

    // Byte 'idx' of a packet built from a stored entry
    function automatic logic [7:0] pick_byte(input logic [ENTRY_W-1:0] entry,
                                             input logic [IDX_W-1:0]   idx);
        logic [DATA_WIDTH-1:0] data;
        logic [7:0]            result;
        data = entry[DATA_WIDTH-1:0];
`ifdef ALU_PKT_HDR_EN
        if (idx == '0) begin
            result = {4'hA, entry[ENTRY_W-1 -: 4]};
        end else begin
            result = 8'(data >> (32'(idx) * 8 - 8));
        end
`else
        result = 8'(data >> (32'(idx) * 8));
`endif
        return result;
    endfunction

    // Pointer advance, modulo DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef ALU_PKT_HDR_EN
    assign push_entry = {ALU_FUN, ALU_OUT};
`else
    logic unused_fun;
    assign unused_fun = ^ALU_FUN;
    assign push_entry = ALU_OUT;
`endif

    assign head_entry = mem[rd_ptr];
    assign next_entry = mem[ptr_inc(rd_ptr)];

    // Handshake and FIFO push/pop qualification
    assign transfer  = TX_VALID & TX_READY;
    assign last_byte = (byte_idx == LAST_IDX);
    assign pop       = transfer & last_byte;
    assign push      = OUT_VALID & ((count < FULL_CNT) | pop);
    assign drop      = OUT_VALID & ~push;

    // Occupancy update; simultaneous push and pop leave it unchanged
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Serialiser FSM: next state and next registered TX outputs
    always_comb begin
        state_next    = state;
        idx_next      = byte_idx;
        tx_data_next  = TX_DATA;
        tx_valid_next = TX_VALID;
        case (state)
            IDLE: begin
                tx_valid_next = 1'b0;
                if (count != '0) begin
                    state_next    = SEND;
                    idx_next      = '0;
                    tx_data_next  = pick_byte(head_entry, '0);
                    tx_valid_next = 1'b1;
                end
            end
            SEND: begin
                tx_valid_next = 1'b1;
                if (transfer) begin
                    if (!last_byte) begin
                        idx_next     = byte_idx + IDX_W'(1);
                        tx_data_next = pick_byte(head_entry, byte_idx + IDX_W'(1));
                    end else begin
                        idx_next = '0;
                        // Keep streaming from the following entry; if the only
                        // remaining entry is the one arriving now, take it
                        // straight from the inputs.
                        if (count > CNT_W'(1)) begin
                            tx_data_next = pick_byte(next_entry, '0);
                        end else if (push) begin
                            tx_data_next = pick_byte(push_entry, '0);
                        end else begin
                            state_next    = IDLE;
                            tx_valid_next = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                idx_next      = '0;
                tx_valid_next = 1'b0;
            end
        endcase
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            byte_idx <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            state    <= state_next;
            byte_idx <= idx_next;
            TX_DATA  <= tx_data_next;
            TX_VALID <= tx_valid_next;
            count    <= count_next;
            BUSY     <= (count_next != '0) | tx_valid_next;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (drop) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

    // FIFO storage write; contents need no reset because pointers do
    always_ff @(posedge clk) begin
        if (!RST && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule
